apu_frame_sequencer: RTL and testbench
======================================

# apu_frame_sequencer

Step sequencer for the APU frame-clock domain. A programmable prescaler divides `clk` into step ticks. A 4-step or 5-step sequence engine turns those ticks into one-cycle quarter-frame and half-frame pulses for the envelope, linear, length and sweep units, plus a latched frame IRQ. It sits between the CPU-side register write decode ($4017 equivalent) and the channel units, and replaces free-running divided clocks with synchronous enable pulses.

## Interface
- `PRESCALE`, default 20: `clk` cycles per sequence step (4800 Hz / 240 Hz).
- `CNT_W`, default 5: prescaler counter width; must satisfy 2^CNT_W >= PRESCALE.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_we`  in  1  one-cycle write strobe for frame configuration.
- `cfg_mode`  in  1  sequence mode, sampled on `cfg_we`: 0 = 4-step, 1 = 5-step.
- `cfg_irq_inhibit`  in  1  IRQ inhibit, sampled on `cfg_we`.
- `irq_ack`  in  1  one-cycle pulse that clears `irq`.
- `qtr_pulse`  out  1  quarter-frame enable, one cycle wide.
- `hlf_pulse`  out  1  half-frame enable, one cycle wide.
- `irq`  out  1  latched frame interrupt flag.
- `step`  out  3  index of the next step to execute.

## Operation
- Reset values (applied asynchronously):
  - prescaler count 0.
  - `step`=0, mode=0, inhibit=0.
  - `qtr_pulse`=`hlf_pulse`=`irq`=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - The terminal count (TC) cycle produces an internal tick.
- On a tick the current `step` executes, then `step` advances.
- Mode 0 (4-step), wraps 3→0:
  - steps 0 and 2: qtr only.
  - steps 1 and 3: qtr and hlf.
  - step 3 also sets `irq` if inhibit=0.
- Mode 1 (5-step), wraps 4→0:
  - steps 0 and 2: qtr.
  - steps 1 and 4: qtr and hlf.
  - step 3: no event.
  - `irq` is never set in mode 1.
- `cfg_we`:
  - Latches mode and inhibit.
  - Clears the prescaler to 0 and `step` to 0.
  - If `cfg_mode`=1, issues `qtr_pulse` and `hlf_pulse` together in the next cycle.
  - If `cfg_irq_inhibit`=1, clears `irq`.
- `irq` stays set until `irq_ack` or an inhibiting write.
- Simultaneous events:
  - `cfg_we` on a TC cycle: the write wins. The tick is discarded, no step pulses are issued, and only the mode-1 immediate pulses (if any) appear.
  - `irq_ack` on the cycle that sets `irq`: set wins, so `irq` stays 1.
  - `irq_ack` with `cfg_we` and inhibit=0: ack clears `irq`.
- Switching from mode 1 to mode 0 while at `step`=4 is impossible, because every write resets `step` to 0.

## Timing
- Pulses are registered. Each is high for exactly the one cycle after the TC cycle (or after the `cfg_we` cycle).
- `step` updates on the same edge that raises the pulses.
- `irq` rises on the same edge as the step-3 pulses. It falls one edge after `irq_ack`.
- After reset release or a `cfg_we`, the first tick pulse appears PRESCALE cycles later; later pulses follow every PRESCALE cycles.
- No handshake. Consumers sample the pulses as clock enables in the same `clk` domain.

## Configuration
- `FRAME_IRQ_EN` defined:
  - IRQ latch, inhibit bit and `irq_ack` logic are present as described.
- `FRAME_IRQ_EN` undefined:
  - The `irq` port remains and is tied to 0.
  - `cfg_irq_inhibit` and `irq_ack` are ignored.
  - No IRQ flop is synthesised.
  - Pulse behaviour is unchanged.

## Structure
- Package `apu_frame_pkg` holds:
  - mode encodings MODE_4STEP=0 and MODE_5STEP=1.
  - last-step constants LAST_STEP_4=3 and LAST_STEP_5=4.
  - `step` width constant STEP_W=3.
- Sub-module `frame_prescaler`:
  - Parameterised by PRESCALE and CNT_W.
  - Inputs: `clk`, `rst`, synchronous clear.
  - Output: one-cycle `tick` on TC.
- The sequence decode, pulse registers and IRQ latch live in the top module.

## Test plan
All scenarios use PRESCALE=20.
- Reset release, mode 0, run 80 cycles -> `qtr_pulse` at cycles 20/40/60/80, `hlf_pulse` at 40/80, `irq` rises at 80, `step` returns to 0.
- `cfg_we` with mode=1 -> `qtr_pulse` and `hlf_pulse` the next cycle. Over the following 100 cycles: qtr at +20/+40/+60/+100, hlf at +40/+100, `irq` stays 0.
- With `irq`=1, `cfg_we` with inhibit=1 -> `irq`=0 next cycle. Run 80 more cycles -> `irq` stays 0 and pulses are unchanged.
- `irq_ack` asserted on the step-3 TC cycle -> `irq`=1 afterwards. A second `irq_ack` one cycle later -> `irq`=0.
- `cfg_we` (mode=0) on a TC cycle at `step`=1 -> no pulse that cycle, `step`=0, next `qtr_pulse` 20 cycles later.
- Assert `rst` asynchronously mid-cycle at `step`=2 -> outputs and `step` are 0 before the next edge. After release, the first pulse comes 20 cycles later. Repeat with `FRAME_IRQ_EN` undefined -> `irq` is 0 throughout.

Source files
------------

// File: rtl/apu_frame_sequencer_pkg.sv
// Shared types and constants for the APU frame sequencer: mode encodings,
// step limits and the per-step event decode.
package apu_frame_pkg;

  localparam int STEP_W = 3;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } seq_mode_e;

  localparam logic [STEP_W-1:0] LAST_STEP_4 = 3'd3;
  localparam logic [STEP_W-1:0] LAST_STEP_5 = 3'd4;

  typedef struct packed {
    logic qtr;
    logic hlf;
    logic irq;
  } step_evt_t;

  // Events produced when a given step executes in a given mode
  function automatic step_evt_t decode_step(seq_mode_e mode, logic [STEP_W-1:0] step);
    step_evt_t evt;
    evt = '0;
    case (step)
      3'd0, 3'd2: evt.qtr = 1'b1;
      3'd1: begin
        evt.qtr = 1'b1;
        evt.hlf = 1'b1;
      end
      3'd3: begin
        if (mode == MODE_4STEP) begin
          evt.qtr = 1'b1;
          evt.hlf = 1'b1;
          evt.irq = 1'b1;
        end else begin
          evt = '0;
        end
      end
      3'd4: begin
        if (mode == MODE_5STEP) begin
          evt.qtr = 1'b1;
          evt.hlf = 1'b1;
        end else begin
          evt = '0;
        end
      end
      default: evt = '0;
    endcase
    return evt;
  endfunction

  function automatic logic [STEP_W-1:0] next_step(seq_mode_e mode, logic [STEP_W-1:0] step);
    logic [STEP_W-1:0] last;
    last = (mode == MODE_5STEP) ? LAST_STEP_5 : LAST_STEP_4;
    return (step >= last) ? 3'd0 : step + 3'd1;
  endfunction

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Configuration inputs and frame-clock outputs of the APU frame sequencer.
interface apu_frame_sequencer_if;
  import apu_frame_pkg::*;

  logic              cfg_we;
  logic              cfg_mode;
  logic              cfg_irq_inhibit;
  logic              irq_ack;
  logic              qtr_pulse;
  logic              hlf_pulse;
  logic              irq;
  logic [STEP_W-1:0] step;

  modport master (
    output cfg_we, cfg_mode, cfg_irq_inhibit, irq_ack,
    input  qtr_pulse, hlf_pulse, irq, step
  );

  modport slave (
    input  cfg_we, cfg_mode, cfg_irq_inhibit, irq_ack,
    output qtr_pulse, hlf_pulse, irq, step
  );
endinterface

// File: rtl/apu_frame_sequencer_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 and flags the terminal-count cycle.
module frame_prescaler #(
  parameter int PRESCALE = 20,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc   = (r_cnt == TC_VAL);
  // A clearing cycle never reports a tick so the caller cannot double-count it
  assign o_tick = w_tc & ~i_clr;

  // Prescaler counter with synchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 4/5-step engine producing quarter/half-frame enables
// and the frame IRQ. The IRQ latch exists only when FRAME_IRQ_EN is defined.
module apu_frame_sequencer
  import apu_frame_pkg::*;
#(
  parameter int PRESCALE = 20,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  apu_frame_sequencer_if.slave bus
);

  logic              w_tick;
  seq_mode_e         r_mode;
  seq_mode_e         w_mode_nxt;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_nxt;
  logic              r_qtr;
  logic              r_hlf;
  logic              w_qtr_nxt;
  logic              w_hlf_nxt;
  logic              w_irq_set;
  step_evt_t         w_evt;

  frame_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (bus.cfg_we),
    .o_tick (w_tick)
  );

  // Next-state decode; a config write takes priority over a coincident tick
  always_comb begin
    w_evt      = decode_step(r_mode, r_step);
    w_mode_nxt = r_mode;
    w_step_nxt = r_step;
    w_qtr_nxt  = 1'b0;
    w_hlf_nxt  = 1'b0;
    w_irq_set  = 1'b0;
    if (bus.cfg_we) begin
      w_mode_nxt = seq_mode_e'(bus.cfg_mode);
      w_step_nxt = 3'd0;
      w_qtr_nxt  = bus.cfg_mode;
      w_hlf_nxt  = bus.cfg_mode;
    end else if (w_tick) begin
      w_step_nxt = next_step(r_mode, r_step);
      w_qtr_nxt  = w_evt.qtr;
      w_hlf_nxt  = w_evt.hlf;
      w_irq_set  = w_evt.irq;
    end else begin
      w_step_nxt = r_step;
    end
  end

  // Sequence state and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_4STEP;
      r_step <= 3'd0;
      r_qtr  <= 1'b0;
      r_hlf  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_step <= w_step_nxt;
      r_qtr  <= w_qtr_nxt;
      r_hlf  <= w_hlf_nxt;
    end
  end

  assign bus.qtr_pulse = r_qtr;
  assign bus.hlf_pulse = r_hlf;
  assign bus.step      = r_step;

`ifdef FRAME_IRQ_EN
  logic r_inhibit;
  logic r_irq;

  // IRQ latch: a step-3 set beats a same-cycle acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inhibit <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        r_inhibit <= bus.cfg_irq_inhibit;
      end else begin
        r_inhibit <= r_inhibit;
      end
      if (w_irq_set && !r_inhibit) begin
        r_irq <= 1'b1;
      end else if (bus.irq_ack || (bus.cfg_we && bus.cfg_irq_inhibit)) begin
        r_irq <= 1'b0;
      end else begin
        r_irq <= r_irq;
      end
    end
  end

  assign bus.irq = r_irq;
`else
  logic w_unused_irq_in;
  assign w_unused_irq_in = bus.cfg_irq_inhibit ^ bus.irq_ack ^ w_irq_set;
  assign bus.irq         = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed self-checking bench for apu_frame_sequencer (PRESCALE=20); irq
// expectations follow whether FRAME_IRQ_EN is defined.
module tb_apu_frame_sequencer;

`ifdef FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  apu_frame_sequencer_if bus();

  apu_frame_sequencer #(
    .PRESCALE (20),
    .CNT_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Run n cycles checking qtr/hlf at listed offsets (0 = unused) and irq level
  task automatic run_chk(input string tag, input int n,
                         input int q0, input int q1, input int q2, input int q3,
                         input int h0, input int h1,
                         input bit irq0, input int rise);
    bit eq, eh, ei;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      eq = (i == q0) || (i == q1) || (i == q2) || (i == q3);
      eh = (i == h0) || (i == h1);
      ei = IRQ_EN && (irq0 || (rise != 0 && i >= rise));
      check_eq({tag, "_qtr"}, int'(bus.qtr_pulse), int'(eq));
      check_eq({tag, "_hlf"}, int'(bus.hlf_pulse), int'(eh));
      check_eq({tag, "_irq"}, int'(bus.irq), int'(ei));
    end
  endtask

  task automatic cfg_write(input bit mode, input bit inh, input bit ack);
    bus.cfg_we          = 1'b1;
    bus.cfg_mode        = mode;
    bus.cfg_irq_inhibit = inh;
    bus.irq_ack         = ack;
    @(negedge clk);
    bus.cfg_we          = 1'b0;
    bus.cfg_mode        = 1'b0;
    bus.cfg_irq_inhibit = 1'b0;
    bus.irq_ack         = 1'b0;
  endtask

  initial begin
    n_checks            = 0;
    n_fails             = 0;
    rst                 = 1'b1;
    bus.cfg_we          = 1'b0;
    bus.cfg_mode        = 1'b0;
    bus.cfg_irq_inhibit = 1'b0;
    bus.irq_ack         = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_qtr", int'(bus.qtr_pulse), 0);
    check_eq("rst_hlf", int'(bus.hlf_pulse), 0);
    check_eq("rst_irq", int'(bus.irq), 0);
    check_eq("rst_step", int'(bus.step), 0);

    // Mode 0 from reset
    rst = 1'b0;
    run_chk("s1", 80, 20, 40, 60, 80, 40, 80, 1'b0, 80);
    check_eq("s1_step", int'(bus.step), 0);

    // Mode 1 write with simultaneous ack: immediate pulses, irq cleared
    cfg_write(1'b1, 1'b0, 1'b1);
    check_eq("s2_imm_qtr", int'(bus.qtr_pulse), 1);
    check_eq("s2_imm_hlf", int'(bus.hlf_pulse), 1);
    check_eq("s2_imm_irq", int'(bus.irq), 0);
    check_eq("s2_imm_step", int'(bus.step), 0);
    run_chk("s2", 100, 20, 40, 60, 100, 40, 100, 1'b0, 0);
    check_eq("s2_step", int'(bus.step), 0);

    // Mode 0, raise irq, then clear it with an inhibiting write
    cfg_write(1'b0, 1'b0, 1'b0);
    check_eq("s3_imm_qtr", int'(bus.qtr_pulse), 0);
    check_eq("s3_imm_hlf", int'(bus.hlf_pulse), 0);
    run_chk("s3a", 80, 20, 40, 60, 80, 40, 80, 1'b0, 80);
    cfg_write(1'b0, 1'b1, 1'b0);
    check_eq("s3_inh_irq", int'(bus.irq), 0);
    check_eq("s3_inh_qtr", int'(bus.qtr_pulse), 0);
    run_chk("s3b", 80, 20, 40, 60, 80, 40, 80, 1'b0, 0);

    // Ack on the step-3 TC cycle loses to the set; a second ack clears
    cfg_write(1'b0, 1'b0, 1'b0);
    run_chk("s4", 79, 20, 40, 60, 0, 40, 0, 1'b0, 0);
    bus.irq_ack = 1'b1;
    @(negedge clk);
    check_eq("s4_set_qtr", int'(bus.qtr_pulse), 1);
    check_eq("s4_set_hlf", int'(bus.hlf_pulse), 1);
    check_eq("s4_set_irq", int'(bus.irq), int'(IRQ_EN));
    check_eq("s4_set_step", int'(bus.step), 0);
    @(negedge clk);
    bus.irq_ack = 1'b0;
    check_eq("s4_ack_irq", int'(bus.irq), 0);

    // Write on the TC cycle at step 1 discards the tick
    cfg_write(1'b0, 1'b0, 1'b0);
    run_chk("s5a", 39, 20, 0, 0, 0, 0, 0, 1'b0, 0);
    check_eq("s5_pre_step", int'(bus.step), 1);
    cfg_write(1'b0, 1'b0, 1'b0);
    check_eq("s5_tc_qtr", int'(bus.qtr_pulse), 0);
    check_eq("s5_tc_hlf", int'(bus.hlf_pulse), 0);
    check_eq("s5_tc_step", int'(bus.step), 0);
    run_chk("s5b", 20, 20, 0, 0, 0, 0, 0, 1'b0, 0);
    check_eq("s5_step", int'(bus.step), 1);

    // Asynchronous reset mid-cycle while pulses are high at step 2
    cfg_write(1'b0, 1'b0, 1'b0);
    run_chk("s6a", 40, 20, 40, 0, 0, 40, 0, 1'b0, 0);
    check_eq("s6_pre_step", int'(bus.step), 2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("s6_async_qtr", int'(bus.qtr_pulse), 0);
    check_eq("s6_async_hlf", int'(bus.hlf_pulse), 0);
    check_eq("s6_async_irq", int'(bus.irq), 0);
    check_eq("s6_async_step", int'(bus.step), 0);
    @(negedge clk);
    rst = 1'b0;
    run_chk("s6b", 20, 20, 0, 0, 0, 0, 0, 1'b0, 0);
    check_eq("s6_step", int'(bus.step), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
